train_ctrl: RTL



---
 rtl/train_pkg.sv | 23 ++
 rtl/train_ctrl_settle_timer.sv | 28 ++
 rtl/train_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/train_pkg.sv
// Shared definitions for the batch-training sequencer: state encoding,
// run-mode constants and the strobe-exclusivity check.
package train_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CLR0,
    ST_LOAD,
    ST_SETTLE,
    ST_ACCU,
    ST_WRITE,
    ST_CAP,
    ST_CLR,
    ST_DONE
  } state_t;

  localparam logic MODE_TRAIN = 1'b0;
  localparam logic MODE_INFER = 1'b1;

endpackage

// At most one of the array strobes may be high in any cycle.
`define TRAIN_STROBE_EXCL(a, b, c) assert (!(((a) && (b)) || ((a) && (c)) || ((b) && (c))))

// File: rtl/train_ctrl_settle_timer.sv
// Loadable down-counter; o_tc is high while the count sits at zero, so a load
// of N-1 followed by enabled cycles gives an N-cycle dwell.
module settle_timer #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == '0);

endmodule

// File: rtl/train_ctrl.sv
// Batch-training sequencer: walks the sample store, holds each sample for a
// settle period and issues accumulate / weight-write / batch-clear strobes.
module train_ctrl
  import train_pkg::*;
#(
  parameter int N_IN   = 2,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32,
  parameter int FRAC   = 24,
  parameter int BATCH  = 4,
  parameter int SETTLE = 3,
  parameter int EP_W   = 16,
  parameter int IDX_W  = (BATCH > 1) ? $clog2(BATCH) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_start,
  input  logic                   i_mode,
  input  logic                   i_abort,
  input  logic [EP_W-1:0]        i_epochs,
  input  logic                   i_stop_en,
  input  logic [WIDTH-1:0]       i_cost_thr,
  input  logic [WIDTH-1:0]       i_lr,
  input  logic [N_IN*WIDTH-1:0]  i_rom_k,
  input  logic [N_OUT*WIDTH-1:0] i_rom_t,
  input  logic [WIDTH-1:0]       i_cost,
  output logic [IDX_W-1:0]       o_idx,
  output logic [N_IN*WIDTH-1:0]  o_k,
  output logic [N_OUT*WIDTH-1:0] o_t,
  output logic [WIDTH-1:0]       o_lr,
  output logic                   o_accu,
  output logic                   o_wr,
  output logic                   o_rst_btch,
  output logic [WIDTH-1:0]       o_cost_last,
  output logic                   o_res_vld,
  output logic [EP_W-1:0]        o_epoch,
  output logic                   o_busy,
  output logic                   o_done
);

  localparam int               CNT_W       = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(BATCH - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE - 1);

  // FRAC only describes the fixed-point format seen by the array.
  if (BATCH < 1 || SETTLE < 1 || FRAC >= WIDTH) begin : g_param_check
    $error("train_ctrl: invalid BATCH/SETTLE/FRAC parameters");
  end

  state_t                   r_state, w_state_next;
  logic                     r_mode, r_abort;
  logic [EP_W-1:0]          r_limit, r_epoch;
  logic [IDX_W-1:0]         r_idx;
  logic [N_IN*WIDTH-1:0]    r_k;
  logic [N_OUT*WIDTH-1:0]   r_t;
  logic [WIDTH-1:0]         r_lr, r_cost_last;
  logic                     r_accu, r_wr, r_rst_btch, r_res_vld, r_busy, r_done;
  logic                     w_tc, w_last_idx, w_epoch_inc, w_stop, w_abort_go;
  logic [EP_W-1:0]          w_epoch_new;

  settle_timer #(.CNT_W(CNT_W)) u_settle_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (r_state == ST_LOAD),
    .i_load_val (SETTLE_LOAD),
    .i_en       (r_state == ST_SETTLE),
    .o_tc       (w_tc)
  );

  assign w_last_idx  = (r_idx == LAST_IDX);
  // An aborted run leaves the epoch count where it was.
  assign w_epoch_inc = !r_abort && ((r_mode == MODE_TRAIN) || w_last_idx);
  assign w_epoch_new = r_epoch + EP_W'(w_epoch_inc);
  assign w_stop      = (w_epoch_new == r_limit) ||
                       (i_stop_en && ($signed(r_cost_last) < $signed(i_cost_thr)));

  always_comb begin
    w_state_next = r_state;
    w_abort_go   = 1'b0;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_next = ST_CLR0;
      ST_CLR0:   w_state_next = ST_LOAD;
      ST_LOAD:   w_state_next = ST_SETTLE;
      ST_SETTLE: if (w_tc) w_state_next = ST_ACCU;
      ST_ACCU: begin
        if (r_mode == MODE_INFER)  w_state_next = ST_CAP;
        else if (w_last_idx)       w_state_next = ST_WRITE;
        else                       w_state_next = ST_LOAD;
      end
      ST_WRITE, ST_CAP: w_state_next = ST_CLR;
      ST_CLR:    w_state_next = (r_abort || w_stop) ? ST_DONE : ST_LOAD;
      ST_DONE:   w_state_next = ST_IDLE;
      default:   w_state_next = ST_IDLE;
    endcase
    if (i_abort && (r_state inside {ST_CLR0, ST_LOAD, ST_SETTLE, ST_ACCU, ST_WRITE, ST_CAP})) begin
      w_state_next = ST_CLR;
      w_abort_go   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_TRAIN;
      r_abort     <= 1'b0;
      r_limit     <= '0;
      r_epoch     <= '0;
      r_idx       <= '0;
      r_k         <= '0;
      r_t         <= '0;
      r_lr        <= '0;
      r_cost_last <= '0;
      r_accu      <= 1'b0;
      r_wr        <= 1'b0;
      r_rst_btch  <= 1'b0;
      r_res_vld   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_accu     <= (w_state_next == ST_ACCU);
      r_wr       <= (w_state_next == ST_WRITE);
      r_rst_btch <= (w_state_next == ST_CLR0) || (w_state_next == ST_CLR);
      r_done     <= (w_state_next == ST_DONE);
      r_busy     <= (w_state_next != ST_IDLE);
      r_res_vld  <= (r_state == ST_WRITE) || (r_state == ST_CAP);
      if (w_abort_go) r_abort <= 1'b1;
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_mode      <= i_mode;
            r_limit     <= (i_epochs == '0) ? EP_W'(1) : i_epochs;
            r_lr        <= i_lr;
            r_epoch     <= '0;
            r_idx       <= '0;
            r_cost_last <= '0;
            r_abort     <= 1'b0;
          end
        end
        ST_LOAD: begin
          r_k <= i_rom_k;
          r_t <= i_rom_t;
        end
        ST_ACCU: if (w_state_next == ST_LOAD) r_idx <= r_idx + IDX_W'(1);
        ST_WRITE, ST_CAP: r_cost_last <= i_cost;
        ST_CLR: begin
          if (!r_abort) begin
            r_epoch <= w_epoch_new;
            r_idx   <= ((r_mode == MODE_TRAIN) || w_last_idx) ? '0 : r_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      `TRAIN_STROBE_EXCL(r_accu, r_wr, r_rst_btch);
    end
  end

  assign o_idx       = r_idx;
  assign o_k         = r_k;
  assign o_t         = r_t;
  assign o_lr        = r_lr;
  assign o_accu      = r_accu;
  assign o_wr        = r_wr;
  assign o_rst_btch  = r_rst_btch;
  assign o_cost_last = r_cost_last;
  assign o_res_vld   = r_res_vld;
  assign o_epoch     = r_epoch;
  assign o_busy      = r_busy;
  assign o_done      = r_done;

endmodule
